// File: rtl/sar_pkg.sv
// Shared constants and types for the SAR ADC digital post-processing path.
//   ADC_WIDTH    : conversion word width produced by sarlogic
//   OSR_SEL_W    : width of the averaging-window select
//   OSR_MAX_LOG2 : largest window is 2^OSR_MAX_LOG2 conversions
//   ACC_WIDTH    : accumulator width that cannot wrap at the largest window
package sar_pkg;

  localparam int unsigned ADC_WIDTH    = 10;
  localparam int unsigned OSR_SEL_W    = 3;
  localparam int unsigned OSR_MAX_LOG2 = 7;
  localparam int unsigned ACC_WIDTH    = ADC_WIDTH + OSR_MAX_LOG2;

  // Averaging window state
  typedef enum logic [0:0] {
    WIN_IDLE = 1'b0,
    WIN_ACC  = 1'b1
  } win_state_e;

endpackage : sar_pkg

// File: rtl/sar_fifo.sv
// Synchronous FIFO with first-word-fall-through read side.
// Ports:
//   clk, rstn      : clock, async active-low reset
//   i_clear        : synchronous flush (priority over push/pop)
//   i_push, i_data : write request and word
//   i_pop          : read request; ignored while empty
//   o_head_c       : head word (0 while empty)
//   o_full_c       : FIFO holds DEPTH words
//   o_empty_c      : FIFO holds no words
//   o_level        : registered occupancy
// A push while full succeeds only if a pop frees a slot in the same cycle;
// otherwise the word is dropped and contents are untouched.
module sar_fifo
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH = ADC_WIDTH,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head_c,
  output logic                       o_full_c,
  output logic                       o_empty_c,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  logic             w_do_push;
  logic             w_do_pop;
  logic [LVL_W-1:0] w_level_nxt;

  assign o_full_c  = (r_level == LVL_W'(DEPTH));
  assign o_empty_c = (r_level == '0);
  assign o_level   = r_level;
  assign o_head_c  = o_empty_c ? '0 : r_mem[r_rd_ptr];

  // Push/pop qualification and next occupancy
  always_comb begin
    w_do_pop    = 1'b0;
    w_do_push   = 1'b0;
    w_level_nxt = r_level;
    if (!i_clear) begin
      w_do_pop  = i_pop & ~o_empty_c;
      w_do_push = i_push & (~o_full_c | w_do_pop);
      case ({w_do_push, w_do_pop})
        2'b10:   w_level_nxt = r_level + LVL_W'(1);
        2'b01:   w_level_nxt = r_level - LVL_W'(1);
        default: w_level_nxt = r_level;
      endcase
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= w_level_nxt;
    end
  end

  // Storage; head is masked while empty so no reset is needed here
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule : sar_fifo

// File: rtl/sar_decim.sv
// Decimating averager for SAR conversions: captures each conversion on the
// rising edge of valid_in, averages windows of 2^osr_sel samples and queues
// the averages in a FWFT FIFO with a ready/valid read port.
// Ports:
//   clk, rstn            : clock, async active-low reset
//   valid_in, result_in  : conversion strobe (pulse or level) and word
//   osr_sel              : log2 of window size, latched at window start
//   clear                : synchronous flush of window, FIFO and overflow
//   out_valid/out_ready  : read handshake, out_data is the FIFO head
//   fifo_level           : FIFO occupancy
//   overflow             : sticky, an average was dropped on a full FIFO
module sar_decim
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH      = ADC_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          valid_in,
  input  logic [WIDTH-1:0]              result_in,
  input  logic [OSR_SEL_W-1:0]          osr_sel,
  input  logic                          clear,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int unsigned ACC_W = WIDTH + OSR_MAX_LOG2;
  localparam int unsigned CNT_W = OSR_MAX_LOG2 + 1;

  localparam logic [0:0] S_IDLE = WIN_IDLE;
  localparam logic [0:0] S_ACC  = WIN_ACC;

  logic [0:0]           r_state;
  logic [ACC_W-1:0]     r_acc;
  logic [CNT_W-1:0]     r_count;
  logic [OSR_SEL_W-1:0] r_k;
  logic                 r_valid_d;
  logic                 r_overflow;

  logic [0:0]           w_state_nxt;
  logic [ACC_W-1:0]     w_acc_nxt;
  logic [CNT_W-1:0]     w_count_nxt;
  logic [OSR_SEL_W-1:0] w_k_nxt;
  logic [ACC_W-1:0]     w_sum;
  logic [CNT_W-1:0]     w_count_inc;
  logic                 w_accept;
  logic                 w_push;
  logic [WIDTH-1:0]     w_push_data;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_drop;

  // One sample per rising edge of valid_in
  assign w_accept = valid_in & ~r_valid_d;

  // Edge-detect register follows valid_in even during clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_valid_d <= 1'b0;
    else       r_valid_d <= valid_in;
  end

  // Window state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_count <= '0;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_count <= w_count_nxt;
      r_k     <= w_k_nxt;
    end
  end

  // Window control: accumulate, close on 2^k samples, push the floor average
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_count_nxt = r_count;
    w_k_nxt     = r_k;
    w_push      = 1'b0;
    w_push_data = '0;
    w_sum       = r_acc + ACC_W'(result_in);
    w_count_inc = r_count + CNT_W'(1);
    if (clear) begin
      w_state_nxt = S_IDLE;
      w_acc_nxt   = '0;
      w_count_nxt = '0;
    end else if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          w_k_nxt = osr_sel;
          if (osr_sel == '0) begin
            // Window of one: pass the sample straight through
            w_push      = 1'b1;
            w_push_data = result_in;
          end else begin
            w_acc_nxt   = ACC_W'(result_in);
            w_count_nxt = CNT_W'(1);
            w_state_nxt = S_ACC;
          end
        end
        S_ACC: begin
          if (w_count_inc == (CNT_W'(1) << r_k)) begin
            w_push      = 1'b1;
            w_push_data = WIDTH'(w_sum >> r_k);
            w_acc_nxt   = '0;
            w_count_nxt = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_acc_nxt   = w_sum;
            w_count_nxt = w_count_inc;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_acc_nxt   = '0;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  // A push is lost only when full and no pop frees a slot this cycle
  assign w_drop = w_push & w_fifo_full & ~(out_ready & ~w_fifo_empty);

  // Sticky overflow flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       r_overflow <= 1'b0;
    else if (clear)  r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  sar_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .i_clear   (clear),
    .i_push    (w_push),
    .i_data    (w_push_data),
    .i_pop     (out_ready),
    .o_head_c  (out_data),
    .o_full_c  (w_fifo_full),
    .o_empty_c (w_fifo_empty),
    .o_level   (fifo_level)
  );

  assign out_valid = ~w_fifo_empty;
  assign overflow  = r_overflow;

endmodule : sar_decim

// File: tb/tb_sar_decim.sv
// Directed self-checking bench for sar_decim.
module tb_sar_decim;

  logic       clk;
  logic       rstn;
  logic       valid_in;
  logic [9:0] result_in;
  logic [2:0] osr_sel;
  logic       clear;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_data;
  logic [2:0] fifo_level;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  sar_decim #(
    .WIDTH      (10),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .valid_in   (valid_in),
    .result_in  (result_in),
    .osr_sel    (osr_sel),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample; returns just after the accepting edge with valid_in low
  task automatic accept(input logic [9:0] v);
    valid_in  = 1'b1;
    result_in = v;
    tick();
    valid_in  = 1'b0;
  endtask

  task automatic send(input logic [9:0] v);
    accept(v);
    tick();
  endtask

  // Check head word then pop it
  task automatic pop_check(input string tag, input logic [9:0] exp);
    check(tag, 32'(out_data), 32'(exp));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic early;
    rstn = 1'b0; valid_in = 1'b0; result_in = '0; osr_sel = '0;
    clear = 1'b0; out_ready = 1'b0;
    #3;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    #10 rstn = 1'b1;
    tick();

    // Pass-through
    osr_sel = 3'd0; out_ready = 1'b1;
    valid_in = 1'b1; result_in = 10'h155;
    check("pt_latency", 32'(out_valid), 32'd0);
    tick();
    valid_in = 1'b0;
    check("pt_valid", 32'(out_valid), 32'd1);
    check("pt_data", 32'(out_data), 32'h155);
    check("pt_level1", 32'(fifo_level), 32'd1);
    tick();
    check("pt_popped", 32'(out_valid), 32'd0);
    check("pt_level0", 32'(fifo_level), 32'd0);

    // Average of four with floor
    osr_sel = 3'd2;
    send(10'd100); send(10'd101); send(10'd102);
    check("avg_partial", 32'(out_valid), 32'd0);
    accept(10'd103);
    check("avg_valid", 32'(out_valid), 32'd1);
    check("avg_data", 32'(out_data), 32'd101);
    tick();

    // Level-held valid_in counts once: 8 (held) + 4 + 4 + 4 = 20, /4 = 5
    valid_in = 1'b1; result_in = 10'd8;
    repeat (20) tick();
    valid_in = 1'b0;
    tick();
    check("hold_one", 32'(out_valid), 32'd0);
    send(10'd4); send(10'd4);
    check("hold_partial", 32'(out_valid), 32'd0);
    accept(10'd4);
    check("hold_data", 32'(out_data), 32'd5);
    tick();

    // Full scale, osr_sel changed mid-window
    osr_sel = 3'd7;
    early = 1'b0;
    for (int i = 0; i < 128; i++) begin
      accept(10'h3FF);
      if (i == 10) osr_sel = 3'd1;
      if (i < 127) early = early | out_valid;
      else begin
        check("fs_valid", 32'(out_valid), 32'd1);
        check("fs_data", 32'(out_data), 32'h3FF);
      end
      tick();
    end
    check("fs_early", 32'(early), 32'd0);

    // Overflow
    osr_sel = 3'd0; out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) send(10'(v));
    check("ovf_level", 32'(fifo_level), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    for (int v = 1; v <= 4; v++) pop_check("ovf_drain", 10'(v));
    check("ovf_empty", 32'(out_valid), 32'd0);
    clear = 1'b1; tick(); clear = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
    for (int v = 6; v <= 9; v++) send(10'(v));
    check("fp_full", 32'(fifo_level), 32'd4);
    valid_in = 1'b1; result_in = 10'd10; out_ready = 1'b1;
    tick();
    valid_in = 1'b0; out_ready = 1'b0;
    check("fp_level", 32'(fifo_level), 32'd4);
    check("fp_ovf", 32'(overflow), 32'd0);
    tick();
    for (int v = 7; v <= 10; v++) pop_check("fp_drain", 10'(v));

    // Clear mid-window with queued data, overflow set and a coincident sample
    for (int v = 1; v <= 5; v++) send(10'(v));
    osr_sel = 3'd1;
    send(10'd50);
    clear = 1'b1; valid_in = 1'b1; result_in = 10'd77;
    tick();
    clear = 1'b0;
    tick();
    valid_in = 1'b0;
    tick();
    check("clr_level", 32'(fifo_level), 32'd0);
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    send(10'd10);
    check("clr_partial", 32'(out_valid), 32'd0);
    accept(10'd20);
    check("clr_data", 32'(out_data), 32'd15);
    tick();

    // Async reset mid-window with two words queued
    out_ready = 1'b0; osr_sel = 3'd0;
    send(10'd3); send(10'd4);
    osr_sel = 3'd2;
    send(10'd9); send(10'd9);
    check("ar_pre_level", 32'(fifo_level), 32'd2);
    #2 rstn = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_data", 32'(out_data), 32'd0);
    check("ar_level", 32'(fifo_level), 32'd0);
    check("ar_ovf", 32'(overflow), 32'd0);
    #3 rstn = 1'b1;
    tick();
    out_ready = 1'b1;
    send(10'd12); send(10'd13); send(10'd14);
    check("ar_partial", 32'(out_valid), 32'd0);
    accept(10'd15);
    check("ar_data_avg", 32'(out_data), 32'd13);
    tick();
    check("ar_drained", 32'(fifo_level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sar_decim
